// File: rtl/sample_ctrl.sv
// Per-sample control sequencer for the filter datapath.
// Each accepted sample runs LOAD, then NUM_TAPS MAC cycles, then DONE, which
// emits one cnt_up pulse. A fault inside the MAC phase (an accumulator overflow,
// or a new sample arriving too early) diverts to a sticky ERR state.
// Every output is decoded from registered state, so no input reaches an output
// combinationally.
module sample_ctrl #(
    parameter int NUM_TAPS = 4,
    parameter int TAP_BITS = 2
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                data_ready,
    input  logic                overflow,
    input  logic                clear_req,
    output logic                load_sample,
    output logic                acc_clr,
    output logic                mac_en,
    output logic [TAP_BITS-1:0] tap_idx,
    output logic                cnt_up,
    output logic                clear,
    output logic                modwait,
    output logic                err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        MAC  = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    localparam logic [TAP_BITS-1:0] LAST_TAP = TAP_BITS'(NUM_TAPS - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [TAP_BITS-1:0] r_tap_idx;
    logic [TAP_BITS-1:0] w_next_tap;
    logic                r_clear;

    // State, tap index and clear registers.
    // n_rst is active-high despite its name: a 1 at the clock edge resets.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_state   <= IDLE;
            r_tap_idx <= '0;
            r_clear   <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_tap_idx <= w_next_tap;
            r_clear   <= clear_req;
        end
    end

    // Next-state and next-tap logic.
    // The tap index only advances while the FSM stays in MAC; on every other
    // transition it returns to 0, so it reads 0 in IDLE and ERR.
    // An error during MAC takes priority over completing the last tap.
    always_comb begin
        w_next_state = r_state;
        w_next_tap   = '0;
        case (r_state)
            IDLE: begin
                if (data_ready) w_next_state = LOAD;
            end
            LOAD: begin
                // A data_ready seen during LOAD is deliberately ignored.
                w_next_state = MAC;
            end
            MAC: begin
                if (overflow || data_ready) begin
                    w_next_state = ERR;
                end else if (r_tap_idx == LAST_TAP) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = MAC;
                    w_next_tap   = r_tap_idx + 1'b1;
                end
            end
            DONE: begin
                // A sample already waiting in DONE starts at once (back-to-back).
                w_next_state = data_ready ? LOAD : IDLE;
            end
            ERR: begin
                if (data_ready) w_next_state = LOAD;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Moore output decode from the current state.
    always_comb begin
        load_sample = 1'b0;
        acc_clr     = 1'b0;
        mac_en      = 1'b0;
        cnt_up      = 1'b0;
        modwait     = 1'b0;
        err         = 1'b0;
        case (r_state)
            LOAD: begin
                load_sample = 1'b1;
                acc_clr     = 1'b1;
                modwait     = 1'b1;
            end
            MAC: begin
                mac_en  = 1'b1;
                modwait = 1'b1;
            end
            DONE: begin
                cnt_up  = 1'b1;
                modwait = 1'b1;
            end
            ERR: begin
                err = 1'b1;
            end
            default: ;
        endcase
    end

    assign tap_idx = r_tap_idx;
    assign clear   = r_clear;

endmodule

// File: tb/tb_sample_ctrl.sv
// Scoreboard bench for sample_ctrl.
// The stimulus process drives one cycle of inputs at a time. After each clock
// edge it queues the output vector expected for that cycle. A separate monitor
// samples the outputs on the falling edge, pops the queue and compares.
module tb_sample_ctrl;

    logic       clk;
    logic       n_rst;
    logic       data_ready;
    logic       overflow;
    logic       clear_req;
    logic       load_sample;
    logic       acc_clr;
    logic       mac_en;
    logic [1:0] tap_idx;
    logic       cnt_up;
    logic       clear;
    logic       modwait;
    logic       err;

    sample_ctrl #(.NUM_TAPS(4), .TAP_BITS(2)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .data_ready  (data_ready),
        .overflow    (overflow),
        .clear_req   (clear_req),
        .load_sample (load_sample),
        .acc_clr     (acc_clr),
        .mac_en      (mac_en),
        .tap_idx     (tap_idx),
        .cnt_up      (cnt_up),
        .clear       (clear),
        .modwait     (modwait),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector layout: {load_sample, acc_clr, mac_en, tap_idx[1:0], cnt_up, clear, modwait, err}
    localparam logic [8:0] E_IDLE = 9'b0_0_0_00_0_0_0_0;
    localparam logic [8:0] E_LOAD = 9'b1_1_0_00_0_0_1_0;
    localparam logic [8:0] E_MAC0 = 9'b0_0_1_00_0_0_1_0;
    localparam logic [8:0] E_MAC1 = 9'b0_0_1_01_0_0_1_0;
    localparam logic [8:0] E_MAC2 = 9'b0_0_1_10_0_0_1_0;
    localparam logic [8:0] E_MAC3 = 9'b0_0_1_11_0_0_1_0;
    localparam logic [8:0] E_DONE = 9'b0_0_0_00_1_0_1_0;
    localparam logic [8:0] E_ERR  = 9'b0_0_0_00_0_0_0_1;
    localparam logic [8:0] E_CLR  = 9'b0_0_0_00_0_1_0_0;

    logic [8:0] exp_q[$];
    string      tag_q[$];
    int         n_tests   = 0;
    int         n_fail    = 0;
    int         cnt_seen  = 0;
    bit         cnt_phase = 1'b0;
    bit         stim_done = 1'b0;

    // Apply one cycle of inputs, then queue the outputs expected after the edge.
    // clear is the registered copy of clear_req, and reset forces it to 0.
    task automatic step(input logic r, input logic d, input logic o, input logic c,
                        input logic [8:0] e, input string tag);
        n_rst      = r;
        data_ready = d;
        overflow   = o;
        clear_req  = c;
        @(posedge clk);
        exp_q.push_back(e | ((!r && c) ? E_CLR : 9'd0));
        tag_q.push_back(tag);
        #1;
    endtask

    // One complete sample: data_ready in IDLE/DONE/ERR, 4 MAC taps, ends in DONE.
    task automatic clean_sample(input string tag);
        step(0, 1, 0, 0, E_LOAD, {tag, "_load"});
        step(0, 0, 0, 0, E_MAC0, {tag, "_mac0"});
        step(0, 0, 0, 0, E_MAC1, {tag, "_mac1"});
        step(0, 0, 0, 0, E_MAC2, {tag, "_mac2"});
        step(0, 0, 0, 0, E_MAC3, {tag, "_mac3"});
        step(0, 0, 0, 0, E_DONE, {tag, "_done"});
    endtask

    // Monitor: compare each expected vector, count cnt_up in the bulk phase,
    // and print the summary once stimulus is done and the queue has drained.
    always @(negedge clk) begin
        logic [8:0] act;
        logic [8:0] exp;
        string      tag;
        if (exp_q.size() > 0) begin
            act = {load_sample, acc_clr, mac_en, tap_idx, cnt_up, clear, modwait, err};
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL %s: outputs got %b want %b (ls,ac,mac,tap,cnt,clr,mw,err)",
                         tag, act, exp);
            end
            if (cnt_phase && cnt_up === 1'b1) cnt_seen++;
            if (stim_done && exp_q.size() == 0) begin
                n_tests++;
                if (cnt_seen != 1000) begin
                    n_fail++;
                    $display("FAIL bulk_cnt_up: counted %0d want 1000", cnt_seen);
                end
                $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst      = 1'b1;
        data_ready = 1'b0;
        overflow   = 1'b0;
        clear_req  = 1'b0;

        // 1: reset state, then one clean sample
        step(1, 0, 0, 0, E_IDLE, "rst0");
        step(1, 1, 1, 1, E_IDLE, "rst1");
        step(0, 0, 0, 0, E_IDLE, "idle0");
        clean_sample("t1");
        step(0, 0, 0, 0, E_IDLE, "t1_idle");

        // 2: overflow at tap 2 goes to ERR, ERR is sticky, then recovers
        step(0, 1, 0, 0, E_LOAD, "t2_load");
        step(0, 0, 0, 0, E_MAC0, "t2_mac0");
        step(0, 0, 0, 0, E_MAC1, "t2_mac1");
        step(0, 0, 0, 0, E_MAC2, "t2_mac2");
        step(0, 0, 1, 0, E_ERR,  "t2_ovf_err");
        step(0, 0, 0, 0, E_ERR,  "t2_err_hold");
        step(0, 0, 1, 0, E_ERR,  "t2_err_hold2");
        clean_sample("t2r");
        step(0, 0, 0, 0, E_IDLE, "t2_idle");

        // 3: data_ready in LOAD ignored; overrun at tap 1 goes to ERR; then back-to-back
        step(0, 1, 0, 0, E_LOAD, "t3_load");
        step(0, 1, 0, 0, E_MAC0, "t3_ld_ignore");
        step(0, 0, 0, 0, E_MAC1, "t3_mac1");
        step(0, 1, 0, 0, E_ERR,  "t3_overrun");
        clean_sample("t3a");
        clean_sample("t3b");
        step(0, 0, 0, 0, E_IDLE, "t3_idle");

        // 3b: overflow on the last tap still beats completion
        step(0, 1, 0, 0, E_LOAD, "t3c_load");
        step(0, 0, 0, 0, E_MAC0, "t3c_mac0");
        step(0, 0, 0, 0, E_MAC1, "t3c_mac1");
        step(0, 0, 0, 0, E_MAC2, "t3c_mac2");
        step(0, 0, 0, 0, E_MAC3, "t3c_mac3");
        step(0, 0, 1, 0, E_ERR,  "t3c_last_ovf");

        // 4: reset clears ERR; reset mid-MAC aborts the sample
        step(1, 0, 0, 0, E_IDLE, "t4_rst_err");
        step(0, 1, 0, 0, E_LOAD, "t4_load");
        step(0, 0, 0, 0, E_MAC0, "t4_mac0");
        step(0, 0, 0, 0, E_MAC1, "t4_mac1");
        step(0, 0, 0, 0, E_MAC2, "t4_mac2");
        step(1, 0, 0, 0, E_IDLE, "t4_rst_mac");
        step(0, 0, 0, 0, E_IDLE, "t4_idle");
        clean_sample("t4r");
        step(0, 0, 0, 0, E_IDLE, "t4_idle2");

        // 5: clear_req in the DONE cycle; clear_req in MAC3 (clear together with cnt_up)
        clean_sample("t5a");
        step(0, 0, 0, 1, E_IDLE, "t5_clr_after_done");
        step(0, 0, 0, 0, E_IDLE, "t5_clr_off");
        step(0, 1, 0, 0, E_LOAD, "t5b_load");
        step(0, 0, 0, 0, E_MAC0, "t5b_mac0");
        step(0, 0, 0, 0, E_MAC1, "t5b_mac1");
        step(0, 0, 0, 0, E_MAC2, "t5b_mac2");
        step(0, 0, 0, 0, E_MAC3, "t5b_mac3");
        step(0, 0, 0, 1, E_DONE, "t5b_done_clr");
        step(0, 0, 0, 0, E_IDLE, "t5b_idle");

        // 6: 1000 back-to-back samples
        cnt_phase = 1'b1;
        for (int s = 0; s < 1000; s++) begin
            clean_sample("t6");
        end
        step(0, 0, 0, 0, E_IDLE, "t6_idle");
        stim_done = 1'b1;
    end

endmodule
